// File: rtl/activity_pkg.sv
// Shared types and constants for the activity window tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package activity_pkg;

    // Width and default saturation value of the cumulative counters
    localparam int unsigned CNT_W           = 14;
    localparam int unsigned CNT_MAX_DEFAULT = 9999;

    // Width and saturation value of the per-window step counter
    localparam int unsigned WIN_W   = 8;
    localparam logic [WIN_W-1:0] WIN_SAT = 8'd255;

    // Activity state machine; prefixed so they do not collide with the ACTIVE port
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // Saturating increment: hold at limit instead of wrapping
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value,
                                                input logic [CNT_W-1:0] limit);
        return (value >= limit) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-bit edge detector: rising-only or any-edge, chosen by ANY_EDGE.
// Latency: pulse is combinational against the previous registered sample.
// Backpressure: none; the input is sampled every cycle.
module edge_detect #(
    parameter bit ANY_EDGE = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic level,
    output logic pulse
);

    logic levelQ;

    // History register of the input, cleared so detection restarts cleanly after reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            levelQ <= 1'b0;
        end else begin
            levelQ <= level;
        end
    end

    assign pulse = ANY_EDGE ? (level ^ levelQ) : (level & ~levelQ);

endmodule

// File: rtl/activity_window_tracker.sv
// Counts steps, latches per-window counts, and tracks an IDLE/ACTIVE hysteresis state.
// Latency: all outputs update one cycle after the step or window-boundary edge.
// Backpressure: none; every step and boundary is accepted on the cycle it occurs.
module activity_window_tracker
    import activity_pkg::*;
#(
    parameter int unsigned STEP_THRESH = 2,
    parameter int unsigned ENTER_WIN   = 2,
    parameter int unsigned EXIT_WIN    = 3,
    parameter int unsigned MAX_COUNT   = CNT_MAX_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STEP,
    input  logic             WINDOW_TICK,
    output logic [CNT_W-1:0] TOTAL_STEPS,
    output logic [WIN_W-1:0] WINDOW_STEPS,
    output logic [CNT_W-1:0] ACTIVE_SECS,
    output logic             ACTIVE,
    output logic             WINDOW_DONE
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_COUNT);

    logic             stepEdge;
    logic             boundary;
    logic [WIN_W-1:0] winCnt;
    logic [7:0]       runCnt;
    logic [7:0]       runNext;
    state_t           state;
    state_t           stateNext;
    logic             winActive;

    edge_detect #(.ANY_EDGE(1'b0)) uStepEdge (
        .CLK   (CLK),
        .RESET (RESET),
        .level (STEP),
        .pulse (stepEdge)
    );

    edge_detect #(.ANY_EDGE(1'b1)) uTickEdge (
        .CLK   (CLK),
        .RESET (RESET),
        .level (WINDOW_TICK),
        .pulse (boundary)
    );

    // Hysteresis: classify the closing window and decide the next state and run length
    always_comb begin
        winActive = (32'(winCnt) >= STEP_THRESH);
        stateNext = state;
        runNext   = runCnt;
        if (state == S_IDLE) begin
            if (winActive) begin
                if (32'(runCnt) + 32'd1 >= ENTER_WIN) begin
                    stateNext = S_ACTIVE;
                    runNext   = 8'd0;
                end else begin
                    runNext = runCnt + 8'd1;
                end
            end else begin
                runNext = 8'd0;
            end
        end else begin
            if (!winActive) begin
                if (32'(runCnt) + 32'd1 >= EXIT_WIN) begin
                    stateNext = S_IDLE;
                    runNext   = 8'd0;
                end else begin
                    runNext = runCnt + 8'd1;
                end
            end else begin
                runNext = 8'd0;
            end
        end
    end

    // Cumulative step count, saturating
    always_ff @(posedge CLK) begin
        if (RESET) begin
            TOTAL_STEPS <= '0;
        end else if (stepEdge) begin
            TOTAL_STEPS <= satInc(TOTAL_STEPS, CNT_LIMIT);
        end
    end

    // Per-window counter; a step coinciding with a boundary belongs to the new window
    always_ff @(posedge CLK) begin
        if (RESET) begin
            winCnt       <= '0;
            WINDOW_STEPS <= '0;
            WINDOW_DONE  <= 1'b0;
        end else begin
            WINDOW_DONE <= boundary;
            if (boundary) begin
                WINDOW_STEPS <= winCnt;
                winCnt       <= stepEdge ? WIN_W'(1) : '0;
            end else if (stepEdge && (winCnt != WIN_SAT)) begin
                winCnt <= winCnt + WIN_W'(1);
            end
        end
    end

    // State, run counter and active-window count advance only on window boundaries
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            runCnt      <= 8'd0;
            ACTIVE      <= 1'b0;
            ACTIVE_SECS <= '0;
        end else if (boundary) begin
            state  <= stateNext;
            runCnt <= runNext;
            ACTIVE <= (stateNext == S_ACTIVE);
            if (state == S_ACTIVE) begin
                ACTIVE_SECS <= satInc(ACTIVE_SECS, CNT_LIMIT);
            end
        end
    end

endmodule

// File: tb/tb_activity_window_tracker.sv
// Scoreboard bench: each issued window boundary pushes its expected report;
// a negedge monitor pops and compares whenever WINDOW_DONE is seen.
module tb_activity_window_tracker;

    logic        CLK;
    logic        RESET;
    logic        STEP;
    logic        WINDOW_TICK;
    logic [13:0] TOTAL_STEPS;
    logic [7:0]  WINDOW_STEPS;
    logic [13:0] ACTIVE_SECS;
    logic        ACTIVE;
    logic        WINDOW_DONE;

    activity_window_tracker dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .STEP         (STEP),
        .WINDOW_TICK  (WINDOW_TICK),
        .TOTAL_STEPS  (TOTAL_STEPS),
        .WINDOW_STEPS (WINDOW_STEPS),
        .ACTIVE_SECS  (ACTIVE_SECS),
        .ACTIVE       (ACTIVE),
        .WINDOW_DONE  (WINDOW_DONE)
    );

    typedef struct {
        int win;
        int tot;
        int secs;
        int act;
    } exp_t;

    exp_t sbQ[$];
    int   totalCnt = 0;
    int   badCnt   = 0;
    int   totalExp = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act != exp) begin
            badCnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every WINDOW_DONE cycle must match the oldest expected report
    always @(negedge CLK) begin
        if (!RESET && WINDOW_DONE) begin
            if (sbQ.size() == 0) begin
                check("unexpected_window_done", 1, 0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                check("window_steps", int'(WINDOW_STEPS), e.win);
                check("total_steps",  int'(TOTAL_STEPS),  e.tot);
                check("active_secs",  int'(ACTIVE_SECS),  e.secs);
                check("active",       int'(ACTIVE),       e.act);
            end
        end
    end

    task automatic tick1();
        @(posedge CLK);
        #1;
    endtask

    task automatic addTotal(input int n);
        totalExp = (totalExp + n > 9999) ? 9999 : totalExp + n;
    endtask

    task automatic doReset();
        RESET       = 1'b1;
        STEP        = 1'b0;
        WINDOW_TICK = 1'b0;
        repeat (2) tick1();
        RESET    = 1'b0;
        totalExp = 0;
        @(negedge CLK);
        check("rst_total_steps",  int'(TOTAL_STEPS),  0);
        check("rst_window_steps", int'(WINDOW_STEPS), 0);
        check("rst_active_secs",  int'(ACTIVE_SECS),  0);
        check("rst_active",       int'(ACTIVE),       0);
        check("rst_window_done",  int'(WINDOW_DONE),  0);
        tick1();
    endtask

    task automatic stepPulses(input int n, input int width);
        for (int i = 0; i < n; i++) begin
            STEP = 1'b1;
            repeat (width) tick1();
            STEP = 1'b0;
            tick1();
        end
        addTotal(n);
    endtask

    // Issue one boundary and expect the pulse to have been consumed shortly after
    task automatic boundary(input int expWin, input int expAct, input int expSecs);
        exp_t e;
        WINDOW_TICK = ~WINDOW_TICK;
        e.win  = expWin;
        e.tot  = totalExp;
        e.secs = expSecs;
        e.act  = expAct;
        sbQ.push_back(e);
        repeat (3) tick1();
        check("window_done_seen", sbQ.size(), 0);
    endtask

    // Step counts per window with hand-derived ACTIVE and ACTIVE_SECS after each boundary
    int s2Steps[5] = '{3, 3, 0, 1, 0};
    int s2Act[5]   = '{0, 1, 1, 1, 0};
    int s2Secs[5]  = '{0, 0, 1, 2, 3};
    int s3Steps[4] = '{2, 1, 2, 2};
    int s3Act[4]   = '{0, 0, 0, 1};

    initial begin
        RESET       = 1'b1;
        STEP        = 1'b0;
        WINDOW_TICK = 1'b0;

        // Basic count: five 3-cycle-wide pulses, one boundary
        doReset();
        stepPulses(5, 3);
        boundary(5, 0, 0);

        // Enter after two active windows, exit after three inactive ones
        doReset();
        for (int i = 0; i < 5; i++) begin
            stepPulses(s2Steps[i], 1);
            boundary(s2Steps[i], s2Act[i], s2Secs[i]);
        end

        // An inactive window breaks the entry run
        doReset();
        for (int i = 0; i < 4; i++) begin
            stepPulses(s3Steps[i], 2);
            boundary(s3Steps[i], s3Act[i], 0);
        end

        // Step coinciding with a boundary lands in the new window
        doReset();
        stepPulses(4, 1);
        begin
            exp_t e;
            STEP        = 1'b1;
            WINDOW_TICK = ~WINDOW_TICK;
            addTotal(1);
            e.win  = 4;
            e.tot  = 5;
            e.secs = 0;
            e.act  = 0;
            sbQ.push_back(e);
            tick1();
            STEP = 1'b0;
            repeat (2) tick1();
            check("coincide_done_seen", sbQ.size(), 0);
        end
        boundary(1, 0, 0);
        check("coincide_total", int'(TOTAL_STEPS), 5);

        // Saturation of the cumulative and per-window counters
        doReset();
        stepPulses(10005, 1);
        check("sat_total_hold", int'(TOTAL_STEPS), 9999);
        boundary(255, 0, 0);
        stepPulses(300, 1);
        boundary(255, 1, 0);

        // Reset mid-window while ACTIVE discards the partial window
        check("pre_reset_active", int'(ACTIVE), 1);
        stepPulses(7, 1);
        doReset();
        stepPulses(3, 1);
        check("post_reset_total", int'(TOTAL_STEPS), 3);
        boundary(3, 0, 0);
        stepPulses(2, 1);
        boundary(2, 1, 0);

        repeat (4) tick1();
        check("scoreboard_drained", sbQ.size(), 0);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        badCnt++;
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $fatal(1, "watchdog expired");
    end

endmodule
